// File: rtl/arb_pkg.sv
// Shared types and the circular pick function for the four-way round-robin arbiter.
package arb_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Returns {found, idx}: the first set request at or after start, wrapping mod N_REQ.
   function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [SEL_W-1:0] start);
      logic [SEL_W:0]   res;
      logic [SEL_W-1:0] idx;
      res = {1'b0, {SEL_W{1'b0}}};
      // Walk from the farthest offset down so the nearest hit wins.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = start + SEL_W'(i);
         if (req[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request / grant / handshake bundle between requesters, the arbiter and the mux consumer.
interface rr_arbiter_4_if;
   import arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic             out_ready;
   logic [SEL_W-1:0] select;
   logic [N_REQ-1:0] grant;
   logic             out_valid;
   logic [N_REQ-1:0] ack;
   logic             busy;

   modport master (
      input  req, out_ready,
      output select, grant, out_valid, ack, busy
   );

   modport slave (
      output req, out_ready,
      input  select, grant, out_valid, ack, busy
   );

endinterface

// File: rtl/rr_pick_4.sv
// Combinational circular priority encoder: first asserted req searching upward from start.
module rr_pick_4
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] start,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   logic [SEL_W:0] res_s;

   // Evaluate the shared pick function.
   always_comb begin
      res_s = rr_pick(req, start);
   end

   assign found = res_s[SEL_W];
   assign idx   = res_s[SEL_W-1:0];

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter steering mux_4x1: grants one requester for up to QUANTUM beats, then rotates.
module rr_arbiter_4
   import arb_pkg::*;
#(
   parameter int unsigned QUANTUM = 4,
   parameter int unsigned CNT_W   = 4
) (
   input  logic           clk,
   input  logic           reset,
   rr_arbiter_4_if.master bus
);

   arb_state_t       state_q, state_d;
   logic [SEL_W-1:0] select_q, select_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

   logic             in_grant_s;
   logic             valid_s;
   logic             hs_s;
   logic             release_s;
   logic [SEL_W-1:0] pick_start_s;
   logic             pick_found_s;
   logic [SEL_W-1:0] pick_idx_s;

   assign in_grant_s = (state_q == GRANT);
   assign valid_s    = in_grant_s & bus.req[select_q];
   assign hs_s       = valid_s & bus.out_ready;
   assign release_s  = in_grant_s &
                       ((hs_s & (beat_cnt_q == CNT_W'(QUANTUM - 1))) | ~bus.req[select_q]);

   // One encoder serves both paths: idle searches from ptr, release searches past the current owner.
   assign pick_start_s = in_grant_s ? (select_q + SEL_W'(1)) : ptr_q;

   rr_pick_4 u_pick (
      .req   (bus.req),
      .start (pick_start_s),
      .found (pick_found_s),
      .idx   (pick_idx_s)
   );

   // Next-state and register-input computation.
   always_comb begin
      state_d    = state_q;
      select_d   = select_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_found_s) begin
               state_d    = GRANT;
               select_d   = pick_idx_s;
               grant_d    = 4'b0001 << pick_idx_s;
               beat_cnt_d = {CNT_W{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (release_s) begin
               ptr_d = select_q + SEL_W'(1);
               if (pick_found_s) begin
                  select_d   = pick_idx_s;
                  grant_d    = 4'b0001 << pick_idx_s;
                  beat_cnt_d = {CNT_W{1'b0}};
               end else begin
                  state_d = IDLE;
                  grant_d = 4'b0000;
               end
            end else if (hs_s) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end else begin
               beat_cnt_d = beat_cnt_q;
            end
         end
         default: begin
            state_d    = IDLE;
            grant_d    = 4'b0000;
            beat_cnt_d = {CNT_W{1'b0}};
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         select_q   <= {SEL_W{1'b0}};
         grant_q    <= 4'b0000;
         ptr_q      <= {SEL_W{1'b0}};
         beat_cnt_q <= {CNT_W{1'b0}};
      end else begin
         state_q    <= state_d;
         select_q   <= select_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Handshake outputs are suppressed while reset is held, whatever the registers contain.
   assign bus.select    = select_q;
   assign bus.grant     = grant_q;
   assign bus.out_valid = ~reset & valid_s;
   assign bus.ack       = reset ? 4'b0000 : (grant_q & {N_REQ{hs_s}});
   assign bus.busy      = ~reset & in_grant_s;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: reset, quantum rotation, stall, early release, drop-with-ready, mid-grant reset.
module tb_rr_arbiter_4;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   rr_arbiter_4_if bus ();

   rr_arbiter_4 #(.QUANTUM(4), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
      $fatal(1);
   end

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.req       = 4'b1111;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         next_cycle();
         checks++;
         if (bus.grant !== 4'b0000 || bus.select !== 2'd0 || bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold: grant=%b select=%0d out_valid=%b ack=%b, required 0000 0 0 0000",
                     bus.grant, bus.select, bus.out_valid, bus.ack);
         end
      end
      reset = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b out_valid=%b, required 0 0", bus.busy, bus.out_valid);
      end
      next_cycle();
      checks++;
      if (bus.grant !== 4'b0001 || bus.select !== 2'd0 || bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL first_grant: grant=%b select=%0d out_valid=%b, required 0001 0 1",
                  bus.grant, bus.select, bus.out_valid);
      end
   endtask

   task automatic test_rotation();
      logic [1:0] exp_sel;
      logic [3:0] exp_ack;
      for (int k = 0; k < 16; k++) begin
         exp_sel = 2'((k / 4) % 4);
         exp_ack = 4'b0001 << exp_sel;
         checks++;
         if (bus.select !== exp_sel || bus.ack !== exp_ack || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rotation[%0d]: select=%0d ack=%b out_valid=%b, required %0d %b 1",
                     k, bus.select, bus.ack, bus.out_valid, exp_sel, exp_ack);
         end
         next_cycle();
      end
      checks++;
      if (bus.select !== 2'd0 || bus.grant !== 4'b0001) begin
         errors++;
         $display("FAIL rotation_wrap: select=%0d grant=%b, required 0 0001", bus.select, bus.grant);
      end
   endtask

   task automatic test_stall();
      bus.req       = 4'b0100;
      bus.out_ready = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin
         errors++;
         $display("FAIL stall_drop: out_valid=%b ack=%b, required 0 0000", bus.out_valid, bus.ack);
      end
      next_cycle();
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (bus.select !== 2'd2 || bus.out_valid !== 1'b1 || bus.ack !== 4'b0000 || dut.beat_cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: select=%0d out_valid=%b ack=%b beat_cnt=%0d, required 2 1 0000 0",
                     c, bus.select, bus.out_valid, bus.ack, dut.beat_cnt_q);
         end
         next_cycle();
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.ack !== 4'b0100) begin
         errors++;
         $display("FAIL stall_resume: ack=%b, required 0100", bus.ack);
      end
      for (int j = 1; j < 4; j++) begin
         next_cycle();
         checks++;
         if (bus.ack !== 4'b0100 || dut.beat_cnt_q !== 4'(j)) begin
            errors++;
            $display("FAIL stall_burst[%0d]: ack=%b beat_cnt=%0d, required 0100 %0d",
                     j, bus.ack, dut.beat_cnt_q, j);
         end
      end
      next_cycle();
      checks++;
      if (bus.select !== 2'd2 || bus.grant !== 4'b0100 || bus.busy !== 1'b1 || dut.beat_cnt_q !== 4'd0) begin
         errors++;
         $display("FAIL sole_regrant: select=%0d grant=%b busy=%b beat_cnt=%0d, required 2 0100 1 0",
                  bus.select, bus.grant, bus.busy, dut.beat_cnt_q);
      end
   endtask

   task automatic test_early_release_wrap();
      bus.req = 4'b1000;
      next_cycle();
      checks++;
      if (bus.select !== 2'd3 || bus.grant !== 4'b1000 || bus.ack !== 4'b1000) begin
         errors++;
         $display("FAIL grant3: select=%0d grant=%b ack=%b, required 3 1000 1000",
                  bus.select, bus.grant, bus.ack);
      end
      bus.req = 4'b0001;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin
         errors++;
         $display("FAIL early_drop: out_valid=%b ack=%b, required 0 0000", bus.out_valid, bus.ack);
      end
      next_cycle();
      checks++;
      if (bus.select !== 2'd0 || bus.grant !== 4'b0001 || dut.ptr_q !== 2'd0) begin
         errors++;
         $display("FAIL ptr_wrap: select=%0d grant=%b ptr=%0d, required 0 0001 0",
                  bus.select, bus.grant, dut.ptr_q);
      end
      bus.req = 4'b0000;
      next_cycle();
      checks++;
      if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.select !== 2'd0 || dut.ptr_q !== 2'd1) begin
         errors++;
         $display("FAIL to_idle: grant=%b busy=%b select=%0d ptr=%0d, required 0000 0 0 1",
                  bus.grant, bus.busy, bus.select, dut.ptr_q);
      end
   endtask

   task automatic test_drop_ready();
      bus.req = 4'b0110;
      next_cycle();
      checks++;
      if (bus.select !== 2'd1 || bus.grant !== 4'b0010 || bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL idle_pick_ptr: select=%0d grant=%b out_valid=%b, required 1 0010 1",
                  bus.select, bus.grant, bus.out_valid);
      end
      bus.req = 4'b0100;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin
         errors++;
         $display("FAIL drop_with_ready: out_valid=%b ack=%b, required 0 0000", bus.out_valid, bus.ack);
      end
      next_cycle();
      checks++;
      if (bus.select !== 2'd2 || bus.grant !== 4'b0100 || bus.ack !== 4'b0100) begin
         errors++;
         $display("FAIL drop_next_pick: select=%0d grant=%b ack=%b, required 2 0100 0100",
                  bus.select, bus.grant, bus.ack);
      end
      bus.req = 4'b0101;
      next_cycle();
      checks++;
      if (bus.select !== 2'd2 || bus.grant !== 4'b0100) begin
         errors++;
         $display("FAIL other_req_toggle: select=%0d grant=%b, required 2 0100", bus.select, bus.grant);
      end
      bus.req = 4'b0100;
      next_cycle();
      checks++;
      if (bus.select !== 2'd2 || dut.beat_cnt_q !== 4'd2) begin
         errors++;
         $display("FAIL burst_cnt2: select=%0d beat_cnt=%0d, required 2 2", bus.select, dut.beat_cnt_q);
      end
   endtask

   task automatic test_reset_mid_grant();
      reset = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_force: out_valid=%b ack=%b busy=%b, required 0 0000 0",
                  bus.out_valid, bus.ack, bus.busy);
      end
      next_cycle();
      checks++;
      if (bus.grant !== 4'b0000 || bus.select !== 2'd0 || bus.out_valid !== 1'b0 || dut.ptr_q !== 2'd0) begin
         errors++;
         $display("FAIL reset_mid: grant=%b select=%0d out_valid=%b ptr=%0d, required 0000 0 0 0",
                  bus.grant, bus.select, bus.out_valid, dut.ptr_q);
      end
      reset   = 1'b0;
      bus.req = 4'b0110;
      next_cycle();
      checks++;
      if (bus.select !== 2'd1 || bus.grant !== 4'b0010) begin
         errors++;
         $display("FAIL restart_ptr0: select=%0d grant=%b, required 1 0010", bus.select, bus.grant);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_rotation();
      test_stall();
      test_early_release_wrap();
      test_drop_ready();
      test_reset_mid_grant();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
